// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register: valid/ready handshake, optional skid entry, flush, NOP bubble.
// Latency 1 cycle; SKID=1 gives a registered in_ready, SKID=0 a combinational one.
module id_ex_pipe_reg #(
    parameter int XLEN        = 32,
    parameter int CTRL_W      = 10,
    parameter int SKID        = 1,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [XLEN-1:0]        ir,
    input  logic [XLEN-1:0]        npc,
    input  logic [XLEN-1:0]        rs,
    input  logic [XLEN-1:0]        rt,
    input  logic [XLEN-1:0]        s_ext,
    input  logic [CTRL_W-1:0]      ctrl,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        ir_out,
    output logic [XLEN-1:0]        npc_out,
    output logic [XLEN-1:0]        rs_out,
    output logic [XLEN-1:0]        rt_out,
    output logic [XLEN-1:0]        s_ext_out,
    output logic [CTRL_W-1:0]      ctrl_out,
    output logic [1:0]             occ,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic [XLEN-1:0]   ir;
        logic [XLEN-1:0]   npc;
        logic [XLEN-1:0]   rs;
        logic [XLEN-1:0]   rt;
        logic [XLEN-1:0]   s_ext;
        logic [CTRL_W-1:0] ctrl;
    } bundle_t;

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

    state_t  state, state_nxt;
    bundle_t m_ent, s_ent, in_b;
    logic    load_m, load_s, m_from_s;
    logic    in_ready_q;
    logic    xfer_in, xfer_out;

    assign in_b      = '{ir: ir, npc: npc, rs: rs, rt: rt, s_ext: s_ext, ctrl: ctrl};
    assign out_valid = (state != EMPTY);
    assign in_ready  = (SKID != 0) ? in_ready_q : (!out_valid || out_ready);
    assign xfer_in   = in_valid && in_ready;
    assign xfer_out  = out_valid && out_ready;

    always_comb begin
        state_nxt = state;
        load_m    = 1'b0;
        load_s    = 1'b0;
        m_from_s  = 1'b0;
        case (state)
            EMPTY: begin
                if (xfer_in) begin
                    load_m    = 1'b1;
                    state_nxt = ONE;
                end
            end
            ONE: begin
                if (xfer_in && xfer_out) begin
                    load_m = 1'b1;
                end else if (xfer_in && (SKID != 0)) begin
                    load_s    = 1'b1;
                    state_nxt = FULL;
                end else if (xfer_out) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (xfer_out) begin
                    m_from_s  = 1'b1;
                    state_nxt = ONE;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        // Redirect kills everything held and anything arriving this cycle.
        if (flush) begin
            state_nxt = EMPTY;
            load_m    = 1'b0;
            load_s    = 1'b0;
            m_from_s  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            m_ent      <= '0;
            s_ent      <= '0;
            in_ready_q <= 1'b1;
            stall_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            in_ready_q <= (state_nxt != FULL);
            if (load_m) begin
                m_ent <= in_b;
            end else if (m_from_s) begin
                m_ent <= s_ent;
            end
            if (load_s) begin
                s_ent <= in_b;
            end
            if (in_valid && !in_ready && (stall_cnt != {STALL_CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    assign occ       = state;
    assign ir_out    = m_ent.ir;
    assign npc_out   = m_ent.npc;
    assign rs_out    = m_ent.rs;
    assign rt_out    = m_ent.rt;
    assign s_ext_out = m_ent.s_ext;
    // Execute sees a NOP whenever the head is invalid.
    assign ctrl_out  = out_valid ? m_ent.ctrl : '0;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg: a SKID=1 instance and a SKID=0 instance.
module tb_id_ex_pipe_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] ir, npc, rs, rt, s_ext;
    logic [9:0]  ctrl;
    logic [31:0] ir_out, npc_out, rs_out, rt_out, s_ext_out;
    logic [9:0]  ctrl_out;
    logic [1:0]  occ;
    logic [15:0] stall_cnt;

    logic        z_in_valid, z_in_ready, z_flush, z_out_valid, z_out_ready;
    logic [31:0] z_ir;
    logic [9:0]  z_ctrl;
    logic [31:0] z_ir_out, z_npc_out, z_rs_out, z_rt_out, z_s_ext_out;
    logic [9:0]  z_ctrl_out;
    logic [1:0]  z_occ;
    logic [15:0] z_stall_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_ex_pipe_reg #(.XLEN(32), .CTRL_W(10), .SKID(1), .STALL_CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ir(ir), .npc(npc), .rs(rs), .rt(rt), .s_ext(s_ext), .ctrl(ctrl),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .ir_out(ir_out), .npc_out(npc_out), .rs_out(rs_out), .rt_out(rt_out),
        .s_ext_out(s_ext_out), .ctrl_out(ctrl_out), .occ(occ), .stall_cnt(stall_cnt)
    );

    id_ex_pipe_reg #(.XLEN(32), .CTRL_W(10), .SKID(0), .STALL_CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .in_valid(z_in_valid), .in_ready(z_in_ready),
        .ir(z_ir), .npc(npc), .rs(rs), .rt(rt), .s_ext(s_ext), .ctrl(z_ctrl),
        .flush(z_flush), .out_valid(z_out_valid), .out_ready(z_out_ready),
        .ir_out(z_ir_out), .npc_out(z_npc_out), .rs_out(z_rs_out), .rt_out(z_rt_out),
        .s_ext_out(z_s_ext_out), .ctrl_out(z_ctrl_out), .occ(z_occ), .stall_cnt(z_stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Side operands are derived from ir so each bundle's fields are distinguishable.
    task automatic put(input logic [31:0] v, input logic [9:0] c);
        ir    = v;
        npc   = v + 32'd4;
        rs    = v ^ 32'hFFFF_0000;
        rt    = {v[30:0], 1'b0};
        s_ext = ~v;
        ctrl  = c;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; flush = 1'b0; out_ready = 1'b0;
        put(32'hDEAD_BEEF, 10'h3FF);
        z_in_valid = 1'b0; z_flush = 1'b0; z_out_ready = 1'b0; z_ir = '0; z_ctrl = '0;
        tick();
        tick();
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_occ",       {30'd0, occ},       32'd0);
        chk("rst_ir_out",    ir_out,             32'd0);
        chk("rst_ctrl_out",  {22'd0, ctrl_out},  32'd0);
        chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);

        // Streaming at full rate
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            put(32'h100 + i, 10'(i));
            tick();
            chk("stream_out_valid", {31'd0, out_valid}, 32'd1);
            chk("stream_ir_out",    ir_out,             32'h100 + i);
            chk("stream_npc_out",   npc_out,            32'h104 + i);
            chk("stream_ctrl_out",  {22'd0, ctrl_out},  32'(i));
            chk("stream_occ",       {30'd0, occ},       32'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("stream_drain_valid", {31'd0, out_valid}, 32'd0);
        chk("stream_hold_rs",     rs_out,             32'hFFFF_0107);
        chk("stream_hold_rt",     rt_out,             32'h0000_020E);
        chk("stream_hold_sext",   s_ext_out,          32'hFFFF_FEF8);
        chk("stream_stall_cnt",   {16'd0, stall_cnt}, 32'd0);

        // Backpressure into the skid entry
        out_ready = 1'b0;
        in_valid  = 1'b1;
        put(32'hA, 10'h001);
        tick();
        chk("bp_a_ir_out",   ir_out,            32'hA);
        chk("bp_a_in_ready", {31'd0, in_ready}, 32'd1);
        put(32'hB, 10'h002);
        tick();
        chk("bp_b_occ",      {30'd0, occ},      32'd2);
        chk("bp_b_in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_b_ir_out",   ir_out,            32'hA);
        put(32'hC, 10'h003);
        tick();
        chk("bp_stall1", {16'd0, stall_cnt}, 32'd1);
        tick();
        chk("bp_stall2",   {16'd0, stall_cnt}, 32'd2);
        chk("bp_full_occ", {30'd0, occ},       32'd2);
        chk("bp_head_a",   ir_out,             32'hA);
        out_ready = 1'b1;
        tick();
        chk("bp_head_b",      ir_out,             32'hB);
        chk("bp_b_ctrl",      {22'd0, ctrl_out},  32'h002);
        chk("bp_occ_one",     {30'd0, occ},       32'd1);
        chk("bp_ready_back",  {31'd0, in_ready},  32'd1);
        chk("bp_stall3",      {16'd0, stall_cnt}, 32'd3);
        tick();
        chk("bp_head_c", ir_out,       32'hC);
        chk("bp_c_occ",  {30'd0, occ}, 32'd1);
        in_valid = 1'b0;
        tick();
        chk("bp_empty", {31'd0, out_valid}, 32'd0);

        // Flush from FULL with a competing transfer-in
        out_ready = 1'b0;
        in_valid  = 1'b1;
        put(32'h1, 10'h155);
        tick();
        put(32'h2, 10'h155);
        tick();
        chk("fl_pre_occ", {30'd0, occ}, 32'd2);
        flush = 1'b1;
        put(32'hF0, 10'h0AA);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("fl_out_valid", {31'd0, out_valid}, 32'd0);
        chk("fl_ctrl_out",  {22'd0, ctrl_out},  32'd0);
        chk("fl_occ",       {30'd0, occ},       32'd0);
        chk("fl_in_ready",  {31'd0, in_ready},  32'd1);
        chk("fl_stall_kept", {16'd0, stall_cnt}, 32'd4);
        out_ready = 1'b1;
        tick();
        chk("fl_no_f0_valid", {31'd0, out_valid}, 32'd0);
        chk("fl_no_f0_ir",    ir_out,             32'h1);

        // Bubble: ctrl visible while valid, zero once consumed
        out_ready = 1'b0;
        in_valid  = 1'b1;
        put(32'h55, 10'h3FF);
        tick();
        in_valid = 1'b0;
        chk("bub_ctrl_full", {22'd0, ctrl_out}, 32'h3FF);
        out_ready = 1'b1;
        tick();
        chk("bub_ctrl_zero", {22'd0, ctrl_out},  32'h000);
        chk("bub_ir_hold",   ir_out,             32'h55);
        chk("bub_valid",     {31'd0, out_valid}, 32'd0);

        // SKID=0 instance: combinational in_ready
        out_ready   = 1'b0;
        z_out_ready = 1'b0;
        z_in_valid  = 1'b1;
        z_ir        = 32'h11;
        z_ctrl      = 10'h2AA;
        put(32'h77, 10'h000);
        tick();
        chk("z_valid",    {31'd0, z_out_valid}, 32'd1);
        chk("z_ir_11",    z_ir_out,             32'h11);
        chk("z_ctrl_2aa", {22'd0, z_ctrl_out},  32'h2AA);
        chk("z_npc",      z_npc_out,            32'h7B);
        z_ir   = 32'h22;
        z_ctrl = 10'h155;
        #1;
        chk("z_ready_low", {31'd0, z_in_ready}, 32'd0);
        z_out_ready = 1'b1;
        #1;
        chk("z_ready_comb", {31'd0, z_in_ready}, 32'd1);
        tick();
        chk("z_replace_ir", z_ir_out,            32'h22);
        chk("z_occ_one",    {30'd0, z_occ},      32'd1);
        chk("z_rs",         z_rs_out,            32'hFFFF_0077);
        chk("z_rt",         z_rt_out,            32'h0000_00EE);
        chk("z_sext",       z_s_ext_out,         32'hFFFF_FF88);
        z_in_valid = 1'b0;
        tick();
        chk("z_occ_zero",   {30'd0, z_occ},       32'd0);
        chk("z_ctrl_nop",   {22'd0, z_ctrl_out},  32'd0);
        chk("z_stall",      {16'd0, z_stall_cnt}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
